chart_sequencer: RTL and testbench

Drives one song's judging loop: fetches goal notes from a synchronous chart ROM, tracks game time, and timestamps player hits. Presents each goal/hit pair plus running state to Scoring, then captures Scoring's base_score/bonus_score/combo and accumulates totals. It sits between the chart ROM, the input/keyboard front end and Scoring, and feeds the game-over and level display logic.

---
 rtl/chart_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_chart_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// Song judging loop: walks the chart ROM note by note, times player hits against
// each goal note, and accumulates the results Scoring hands back.
module chart_sequencer #(
    parameter int unsigned CLOCK_W  = 20,
    parameter int unsigned OCT_W    = 3,
    parameter int unsigned NOTE_W   = 4,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned NUM_W    = 16,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MISS_WIN = 188
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              tick_en,
    input  logic                              hit_valid,
    input  logic [OCT_W-1:0]                  hit_octave,
    input  logic [NOTE_W-1:0]                 hit_note,
    input  logic [LEN_W-1:0]                  hit_length,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic                              rom_rd,
    input  logic [CLOCK_W+OCT_W+NOTE_W+LEN_W-1:0] rom_data,
    output logic [CLOCK_W-1:0]                play_clock,
    output logic [OCT_W-1:0]                  play_octave,
    output logic [NOTE_W-1:0]                 play_note,
    output logic [LEN_W-1:0]                  play_length,
    output logic [CLOCK_W-1:0]                goal_clock,
    output logic [OCT_W-1:0]                  goal_octave,
    output logic [NOTE_W-1:0]                 goal_note,
    output logic [LEN_W-1:0]                  goal_length,
    output logic [NUM_W-1:0]                  total_note,
    output logic [NUM_W-1:0]                  now_cnt,
    output logic [NUM_W-1:0]                  last_combo,
    output logic [NUM_W-1:0]                  last_base_score,
    input  logic [NUM_W-1:0]                  sc_base_score,
    input  logic [NUM_W-1:0]                  sc_bonus_score,
    input  logic [NUM_W-1:0]                  sc_combo,
    output logic [NUM_W-1:0]                  total_score,
    output logic [NUM_W-1:0]                  max_combo,
    output logic                              busy,
    output logic                              done,
    output logic                              judge_pulse,
    output logic                              judge_miss
);

    localparam int unsigned DATA_W = CLOCK_W + OCT_W + NOTE_W + LEN_W;
    localparam logic [CLOCK_W:0] L_MISS = (CLOCK_W+1)'(MISS_WIN);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_RD, S_HDR_WAIT, S_FETCH, S_FETCH_WAIT, S_ARMED, S_JUDGE, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CLOCK_W-1:0] r_game_time;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [CLOCK_W-1:0] r_play_clock, r_goal_clock;
    logic [OCT_W-1:0]   r_play_octave, r_goal_octave;
    logic [NOTE_W-1:0]  r_play_note, r_goal_note;
    logic [LEN_W-1:0]   r_play_length, r_goal_length;
    logic [NUM_W-1:0]   r_total_note, r_now_cnt, r_last_combo, r_last_base;
    logic [NUM_W-1:0]   r_total_score, r_max_combo;
    logic               r_judge_pulse, r_judge_miss;

    logic [CLOCK_W-1:0] w_rom_clock;
    logic [OCT_W-1:0]   w_rom_oct;
    logic [NOTE_W-1:0]  w_rom_note;
    logic [LEN_W-1:0]   w_rom_len;
    logic [NUM_W-1:0]   w_hdr_cnt;
    logic [NUM_W-1:0]   w_cnt_inc;
    logic [NUM_W+1:0]   w_score_sum;
    logic [NUM_W-1:0]   w_score_sat;
    logic               w_hit_ok, w_miss, w_hit_take, w_last, w_running;

    assign w_rom_clock = rom_data[DATA_W-1 -: CLOCK_W];
    assign w_rom_oct   = rom_data[OCT_W+NOTE_W+LEN_W-1 -: OCT_W];
    assign w_rom_note  = rom_data[NOTE_W+LEN_W-1 -: NOTE_W];
    assign w_rom_len   = rom_data[LEN_W-1:0];
    assign w_hdr_cnt   = rom_data[NUM_W-1:0];

    // Window arithmetic is one bit wider than game time so neither side can wrap.
    assign w_hit_ok   = ({1'b0, r_game_time} + L_MISS) >= {1'b0, r_goal_clock};
    assign w_miss     = {1'b0, r_game_time} > ({1'b0, r_goal_clock} + L_MISS);
    assign w_hit_take = hit_valid && w_hit_ok;
    assign w_cnt_inc  = r_now_cnt + NUM_W'(1);
    assign w_last     = (w_cnt_inc == r_total_note);
    assign w_running  = (r_state != S_IDLE) && (r_state != S_DONE);

    assign w_score_sum = {2'b00, r_total_score} + {2'b00, sc_base_score} + {2'b00, sc_bonus_score};
    assign w_score_sat = (|w_score_sum[NUM_W+1:NUM_W]) ? '1 : w_score_sum[NUM_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) w_state_nxt = S_HDR_RD;
                S_HDR_RD:       w_state_nxt = S_HDR_WAIT;
                S_HDR_WAIT:     w_state_nxt = (w_hdr_cnt == '0) ? S_DONE : S_FETCH;
                S_FETCH:        w_state_nxt = S_FETCH_WAIT;
                S_FETCH_WAIT:   w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if (w_hit_take)  w_state_nxt = S_JUDGE;
                    else if (w_miss) w_state_nxt = w_last ? S_DONE : S_FETCH;
                end
                S_JUDGE:        w_state_nxt = w_last ? S_DONE : S_FETCH;
                default:        w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_game_time   <= '0;
            r_rom_addr    <= '0;
            r_play_clock  <= '0;
            r_play_octave <= '0;
            r_play_note   <= '0;
            r_play_length <= '0;
            r_goal_clock  <= '0;
            r_goal_octave <= '0;
            r_goal_note   <= '0;
            r_goal_length <= '0;
            r_total_note  <= '0;
            r_now_cnt     <= '0;
            r_last_combo  <= '0;
            r_last_base   <= '0;
            r_total_score <= '0;
            r_max_combo   <= '0;
            r_judge_pulse <= 1'b0;
            r_judge_miss  <= 1'b0;
        end else begin
            r_judge_pulse <= 1'b0;
            if (!abort) begin
                if (w_running && tick_en && !(&r_game_time))
                    r_game_time <= r_game_time + CLOCK_W'(1);
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_game_time   <= '0;
                            r_now_cnt     <= '0;
                            r_last_combo  <= '0;
                            r_last_base   <= '0;
                            r_total_score <= '0;
                            r_max_combo   <= '0;
                            r_rom_addr    <= '0;
                        end
                    end
                    S_HDR_WAIT: begin
                        r_total_note <= w_hdr_cnt;
                        if (w_hdr_cnt != '0) r_rom_addr <= ADDR_W'(1);
                    end
                    S_FETCH_WAIT: begin
                        r_goal_clock  <= w_rom_clock;
                        r_goal_octave <= w_rom_oct;
                        r_goal_note   <= w_rom_note;
                        r_goal_length <= w_rom_len;
                    end
                    S_ARMED: begin
                        if (w_hit_take) begin
                            r_play_clock  <= r_game_time;
                            r_play_octave <= hit_octave;
                            r_play_note   <= hit_note;
                            r_play_length <= hit_length;
                        end else if (w_miss) begin
                            r_last_combo  <= '0;
                            r_now_cnt     <= w_cnt_inc;
                            r_judge_pulse <= 1'b1;
                            r_judge_miss  <= 1'b1;
                            if (!w_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        end
                    end
                    S_JUDGE: begin
                        r_last_base   <= r_last_base + sc_base_score;
                        r_total_score <= w_score_sat;
                        r_last_combo  <= sc_combo;
                        if (sc_combo > r_max_combo) r_max_combo <= sc_combo;
                        r_now_cnt     <= w_cnt_inc;
                        r_judge_pulse <= 1'b1;
                        r_judge_miss  <= 1'b0;
                        if (!w_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_addr        = r_rom_addr;
    assign rom_rd          = (r_state == S_HDR_RD) || (r_state == S_FETCH);
    assign play_clock      = r_play_clock;
    assign play_octave     = r_play_octave;
    assign play_note       = r_play_note;
    assign play_length     = r_play_length;
    assign goal_clock      = r_goal_clock;
    assign goal_octave     = r_goal_octave;
    assign goal_note       = r_goal_note;
    assign goal_length     = r_goal_length;
    assign total_note      = r_total_note;
    assign now_cnt         = r_now_cnt;
    assign last_combo      = r_last_combo;
    assign last_base_score = r_last_base;
    assign total_score     = r_total_score;
    assign max_combo       = r_max_combo;
    assign busy            = w_running;
    assign done            = (r_state == S_DONE);
    assign judge_pulse     = r_judge_pulse;
    assign judge_miss      = r_judge_miss;

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: directed song scenarios plus a randomized chart
// judged against a timeline model of hit windows and score accumulation.
module tb_chart_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, tick_en, hit_valid;
    logic [2:0]  hit_octave;
    logic [3:0]  hit_note, hit_length;
    logic [9:0]  rom_addr;
    logic        rom_rd;
    logic [30:0] rom_data;
    logic [19:0] play_clock, goal_clock;
    logic [2:0]  play_octave, goal_octave;
    logic [3:0]  play_note, goal_note, play_length, goal_length;
    logic [15:0] total_note, now_cnt, last_combo, last_base_score;
    logic [15:0] sc_base_score, sc_bonus_score, sc_combo;
    logic [15:0] total_score, max_combo;
    logic        busy, done, judge_pulse, judge_miss;

    logic [30:0] chart [0:1023];
    int n_checks = 0;
    int n_pass   = 0;
    int m_time   = 0;

    chart_sequencer #(
        .CLOCK_W(20), .OCT_W(3), .NOTE_W(4), .LEN_W(4),
        .NUM_W(16), .ADDR_W(10), .MISS_WIN(188)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick_en(tick_en),
        .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note),
        .hit_length(hit_length), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_data(rom_data), .play_clock(play_clock), .play_octave(play_octave),
        .play_note(play_note), .play_length(play_length), .goal_clock(goal_clock),
        .goal_octave(goal_octave), .goal_note(goal_note), .goal_length(goal_length),
        .total_note(total_note), .now_cnt(now_cnt), .last_combo(last_combo),
        .last_base_score(last_base_score), .sc_base_score(sc_base_score),
        .sc_bonus_score(sc_bonus_score), .sc_combo(sc_combo),
        .total_score(total_score), .max_combo(max_combo), .busy(busy),
        .done(done), .judge_pulse(judge_pulse), .judge_miss(judge_miss)
    );

    always #5 clk = ~clk;

    // Synchronous chart ROM: word read on rom_rd appears the following cycle.
    always @(posedge clk) if (rom_rd) rom_data <= chart[rom_addr];

    function automatic logic [30:0] mk(input int c, input int o, input int n, input int l);
        logic [31:0] cu, ou, nu, lu;
        cu = c; ou = o; nu = n; lu = l;
        return {cu[19:0], ou[2:0], nu[3:0], lu[3:0]};
    endfunction

    function automatic logic [30:0] hdr(input int n);
        logic [31:0] t;
        t = n;
        return t[30:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        m_time++;
    endtask

    task automatic go_idle();
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic begin_song();
        start = 1'b1; step(); start = 1'b0;
        m_time = 0;
    endtask

    // Steps until judge_pulse; hits fire while game time equals h1/h2/h3.
    task automatic run_pulse(input int h1, input int h2, input int h3,
                             input int limit, output int tp);
        tp = -1;
        for (int i = 0; i < limit; i++) begin
            hit_valid = (m_time == h1) || (m_time == h2) || (m_time == h3);
            step();
            hit_valid = 1'b0;
            if (judge_pulse) begin
                tp = m_time;
                break;
            end
        end
    endtask

    task automatic chart10();
        chart[0] = hdr(10);
        chart[1] = mk(500, 2, 3, 5);
        chart[2] = mk(1200, 1, 7, 2);
        chart[3] = mk(1600, 4, 9, 1);
        for (int i = 4; i <= 10; i++) chart[i] = mk(1600 + i * 500, 0, i, 3);
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0d want 0", done); else n_pass++;
        n_checks++; if (rom_rd !== 1'b0) $display("FAIL reset_rom_rd: got %0d want 0", rom_rd); else n_pass++;
        n_checks++; if (judge_pulse !== 1'b0) $display("FAIL reset_pulse: got %0d want 0", judge_pulse); else n_pass++;
        n_checks++; if (total_score !== 16'd0) $display("FAIL reset_score: got %0d want 0", total_score); else n_pass++;
        n_checks++; if (goal_clock !== 20'd0) $display("FAIL reset_goal: got %0d want 0", goal_clock); else n_pass++;
        rst = 1'b0; step();
    endtask

    task automatic test_empty_chart();
        int pulses;
        pulses = 0;
        go_idle();
        chart[0] = hdr(0);
        begin_song();
        n_checks++; if (!(busy === 1'b1 && rom_rd === 1'b1 && rom_addr === 10'd0))
            $display("FAIL empty_hdr_rd: got busy=%0d rd=%0d addr=%0d want 1 1 0", busy, rom_rd, rom_addr); else n_pass++;
        step(); pulses += judge_pulse;
        n_checks++; if (done !== 1'b0) $display("FAIL empty_done_early: got %0d want 0", done); else n_pass++;
        step(); pulses += judge_pulse;
        n_checks++; if (!(done === 1'b1 && busy === 1'b0))
            $display("FAIL empty_done: got done=%0d busy=%0d want 1 0", done, busy); else n_pass++;
        n_checks++; if (now_cnt !== 16'd0 || total_score !== 16'd0)
            $display("FAIL empty_counts: got cnt=%0d score=%0d want 0 0", now_cnt, total_score); else n_pass++;
        step(); pulses += judge_pulse; step(); pulses += judge_pulse;
        n_checks++; if (pulses != 0) $display("FAIL empty_pulse: got %0d pulses want 0", pulses); else n_pass++;
    endtask

    task automatic test_hit();
        int tp;
        go_idle(); chart10();
        sc_base_score = 16'd50000; sc_bonus_score = 16'd17; sc_combo = 16'd2;
        hit_octave = 3'd2; hit_note = 4'd3; hit_length = 4'd5;
        begin_song();
        run_pulse(505, -1, -1, 700, tp);
        n_checks++; if (tp != 507) $display("FAIL hit_latency: got t=%0d want 507", tp); else n_pass++;
        n_checks++; if (judge_miss !== 1'b0) $display("FAIL hit_miss_flag: got %0d want 0", judge_miss); else n_pass++;
        n_checks++; if (last_base_score !== 16'd50000) $display("FAIL hit_base: got %0d want 50000", last_base_score); else n_pass++;
        n_checks++; if (last_combo !== 16'd2 || max_combo !== 16'd2)
            $display("FAIL hit_combo: got %0d/%0d want 2/2", last_combo, max_combo); else n_pass++;
        n_checks++; if (now_cnt !== 16'd1) $display("FAIL hit_cnt: got %0d want 1", now_cnt); else n_pass++;
        n_checks++; if (total_score !== 16'd50017) $display("FAIL hit_total: got %0d want 50017", total_score); else n_pass++;
        n_checks++; if (play_clock !== 20'd505 || play_note !== 4'd3)
            $display("FAIL hit_play: got clk=%0d note=%0d want 505 3", play_clock, play_note); else n_pass++;
        n_checks++; if (goal_clock !== 20'd500 || goal_note !== 4'd3)
            $display("FAIL hit_goal: got clk=%0d note=%0d want 500 3", goal_clock, goal_note); else n_pass++;
        n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 10'd2)
            $display("FAIL hit_next_fetch: got rd=%0d addr=%0d want 1 2", rom_rd, rom_addr); else n_pass++;
    endtask

    task automatic test_miss();
        int tp;
        go_idle(); chart10();
        sc_base_score = 16'd1000; sc_bonus_score = 16'd0; sc_combo = 16'd2;
        begin_song();
        run_pulse(-1, -1, -1, 800, tp);
        n_checks++; if (tp != 690) $display("FAIL miss_time: got t=%0d want 690", tp); else n_pass++;
        n_checks++; if (judge_miss !== 1'b1) $display("FAIL miss_flag: got %0d want 1", judge_miss); else n_pass++;
        n_checks++; if (now_cnt !== 16'd1 || total_score !== 16'd0)
            $display("FAIL miss_counts: got cnt=%0d score=%0d want 1 0", now_cnt, total_score); else n_pass++;
        n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 10'd2)
            $display("FAIL miss_next_fetch: got rd=%0d addr=%0d want 1 2", rom_rd, rom_addr); else n_pass++;
        run_pulse(1200, -1, -1, 800, tp);
        run_pulse(-1, -1, -1, 800, tp);
        n_checks++; if (tp != 1790 || judge_miss !== 1'b1)
            $display("FAIL miss2_time: got t=%0d miss=%0d want 1790 1", tp, judge_miss); else n_pass++;
        n_checks++; if (last_combo !== 16'd0 || max_combo !== 16'd2)
            $display("FAIL miss2_combo: got %0d/%0d want 0/2", last_combo, max_combo); else n_pass++;
        n_checks++; if (total_score !== 16'd1000 || now_cnt !== 16'd3)
            $display("FAIL miss2_counts: got score=%0d cnt=%0d want 1000 3", total_score, now_cnt); else n_pass++;
    endtask

    task automatic test_early_drop();
        int tp;
        go_idle(); chart10();
        hit_note = 4'd6;
        begin_song();
        run_pulse(300, 311, 312, 700, tp);
        n_checks++; if (tp != 314) $display("FAIL early_time: got t=%0d want 314", tp); else n_pass++;
        n_checks++; if (play_clock !== 20'd312 || judge_miss !== 1'b0 || now_cnt !== 16'd1)
            $display("FAIL early_judge: got clk=%0d miss=%0d cnt=%0d want 312 0 1", play_clock, judge_miss, now_cnt); else n_pass++;
    endtask

    task automatic test_hit_miss_same();
        int tp;
        go_idle(); chart10();
        begin_song();
        run_pulse(689, -1, -1, 800, tp);
        n_checks++; if (tp != 691) $display("FAIL tie_time: got t=%0d want 691", tp); else n_pass++;
        n_checks++; if (judge_miss !== 1'b0 || play_clock !== 20'd689)
            $display("FAIL tie_judge: got miss=%0d clk=%0d want 0 689", judge_miss, play_clock); else n_pass++;
    endtask

    task automatic test_abort_restart();
        int tp;
        go_idle(); chart10();
        sc_base_score = 16'd300; sc_bonus_score = 16'd40; sc_combo = 16'd9;
        begin_song();
        run_pulse(500, -1, -1, 700, tp);
        step();
        abort = 1'b1; step(); abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_idle: got busy=%0d done=%0d want 0 0", busy, done); else n_pass++;
        n_checks++; if (now_cnt !== 16'd1 || rom_addr !== 10'd2 || total_score !== 16'd340)
            $display("FAIL abort_hold: got cnt=%0d addr=%0d score=%0d want 1 2 340", now_cnt, rom_addr, total_score); else n_pass++;
        chart[0] = hdr(1);
        begin_song();
        n_checks++; if (now_cnt !== 16'd0 || total_score !== 16'd0 || max_combo !== 16'd0)
            $display("FAIL restart_clear: got cnt=%0d score=%0d max=%0d want 0 0 0", now_cnt, total_score, max_combo); else n_pass++;
        for (int i = 0; i < 10; i++) step();
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (busy !== 1'b1 || rom_rd !== 1'b0 || rom_addr !== 10'd1)
            $display("FAIL start_busy_ignored: got busy=%0d rd=%0d addr=%0d want 1 0 1", busy, rom_rd, rom_addr); else n_pass++;
        run_pulse(500, -1, -1, 700, tp);
        n_checks++; if (tp != 502 || done !== 1'b1 || now_cnt !== 16'd1 || total_note !== 16'd1)
            $display("FAIL restart_done: got t=%0d done=%0d cnt=%0d total=%0d want 502 1 1 1", tp, done, now_cnt, total_note); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tp;
        go_idle(); chart10();
        sc_base_score = 16'd77; sc_bonus_score = 16'd5; sc_combo = 16'd4;
        begin_song();
        run_pulse(500, -1, -1, 700, tp);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || rom_addr !== 10'd0 || goal_clock !== 20'd0)
            $display("FAIL rst_mid_ctrl: got busy=%0d addr=%0d goal=%0d want 0 0 0", busy, rom_addr, goal_clock); else n_pass++;
        n_checks++; if (now_cnt !== 16'd0 || total_score !== 16'd0 || last_combo !== 16'd0 || play_clock !== 20'd0)
            $display("FAIL rst_mid_regs: got cnt=%0d score=%0d combo=%0d play=%0d want 0", now_cnt, total_score, last_combo, play_clock); else n_pass++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        localparam int N = 8;
        int clk_k[N], hit_t[N], early_t[N], base_k[N], bonus_k[N], combo_k[N];
        int oct_k[N], note_k[N], len_k[N];
        int exp_total, exp_lbs, exp_max, exp_tp, tp, mode;
        logic exp_miss;
        go_idle();
        chart[0] = hdr(N);
        for (int k = 0; k < N; k++) begin
            clk_k[k] = 600 + k * 600 + $urandom_range(0, 100);
            mode = $urandom_range(0, 2);
            hit_t[k]   = (mode == 0) ? -1 : clk_k[k] - 188 + $urandom_range(0, 376);
            early_t[k] = (mode == 2) ? clk_k[k] - 188 - $urandom_range(1, 60) : -1;
            base_k[k]  = $urandom_range(0, 20000);
            bonus_k[k] = $urandom_range(0, 20000);
            combo_k[k] = $urandom_range(0, 1000);
            oct_k[k] = $urandom_range(0, 7); note_k[k] = $urandom_range(0, 15); len_k[k] = $urandom_range(0, 15);
            chart[k + 1] = mk(clk_k[k], $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        end
        exp_total = 0; exp_lbs = 0; exp_max = 0;
        begin_song();
        for (int k = 0; k < N; k++) begin
            sc_base_score = base_k[k][15:0]; sc_bonus_score = bonus_k[k][15:0]; sc_combo = combo_k[k][15:0];
            hit_octave = oct_k[k][2:0]; hit_note = note_k[k][3:0]; hit_length = len_k[k][3:0];
            exp_miss = (hit_t[k] < 0);
            exp_tp   = exp_miss ? clk_k[k] + 190 : hit_t[k] + 2;
            if (!exp_miss) begin
                exp_total = exp_total + base_k[k] + bonus_k[k];
                if (exp_total > 65535) exp_total = 65535;
                exp_lbs = (exp_lbs + base_k[k]) % 65536;
                if (combo_k[k] > exp_max) exp_max = combo_k[k];
            end
            run_pulse(hit_t[k], early_t[k], -1, 1200, tp);
            n_checks++; if (tp != exp_tp || judge_miss !== exp_miss)
                $display("FAIL rnd_judge[%0d]: got t=%0d miss=%0d want t=%0d miss=%0d", k, tp, judge_miss, exp_tp, exp_miss); else n_pass++;
            n_checks++; if (now_cnt !== 16'(k + 1) || total_score !== exp_total[15:0] || last_base_score !== exp_lbs[15:0])
                $display("FAIL rnd_score[%0d]: got cnt=%0d tot=%0d lbs=%0d want %0d %0d %0d",
                         k, now_cnt, total_score, last_base_score, k + 1, exp_total, exp_lbs); else n_pass++;
            n_checks++; if (last_combo !== (exp_miss ? 16'd0 : combo_k[k][15:0]) || max_combo !== exp_max[15:0])
                $display("FAIL rnd_combo[%0d]: got last=%0d max=%0d want miss=%0d combo=%0d max=%0d",
                         k, last_combo, max_combo, exp_miss, combo_k[k], exp_max); else n_pass++;
            if (!exp_miss) begin
                n_checks++; if (play_clock !== hit_t[k][19:0] || play_octave !== oct_k[k][2:0] ||
                                play_note !== note_k[k][3:0] || play_length !== len_k[k][3:0])
                    $display("FAIL rnd_play[%0d]: got clk=%0d o=%0d n=%0d l=%0d want %0d %0d %0d %0d", k, play_clock,
                             play_octave, play_note, play_length, hit_t[k], oct_k[k], note_k[k], len_k[k]); else n_pass++;
            end
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL rnd_done: got done=%0d busy=%0d want 1 0", done, busy); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; tick_en = 1'b1; hit_valid = 1'b0;
        hit_octave = '0; hit_note = '0; hit_length = '0;
        sc_base_score = '0; sc_bonus_score = '0; sc_combo = '0;
        test_reset();
        test_empty_chart();
        test_hit();
        test_miss();
        test_early_drop();
        test_hit_miss_same();
        test_abort_restart();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
